// File: rtl/pio_cmd_pkg.sv
// pio_cmd_pkg: shared defaults and types for the PIO command queue.
// Width/depth defaults, occupancy width helper and the command type.
package pio_cmd_pkg;

  localparam int DEF_DATA_W      = 4;
  localparam int DEF_DEPTH       = 8;
  localparam int DEF_SYNC_STAGES = 2;

  // Occupancy needs one extra bit so that a full queue reads as DEPTH.
  function automatic int level_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

  localparam int LEVEL_W = $clog2(DEF_DEPTH) + 1;

  typedef logic [DEF_DATA_W-1:0] cmd_t;

endpackage

// File: rtl/pio_cmd_sync_fifo.sv
// pio_cmd_sync_fifo: generic single-clock show-ahead FIFO.
// The head entry is held in a register so o_data is a flop output.
module pio_cmd_sync_fifo
  import pio_cmd_pkg::*;
#(
  parameter int W = DEF_DATA_W,
  parameter int D = DEF_DEPTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_push,
  input  logic [W-1:0]          i_data,
  input  logic                  i_pop,
  output logic [W-1:0]          o_data,
  output logic [level_w(D)-1:0] o_level,
  output logic                  o_full,
  output logic                  o_empty
);

  localparam int AW = $clog2(D);
  localparam int LW = level_w(D);

  logic [W-1:0]  r_mem [D];
  logic [LW-1:0] r_wr_cnt;
  logic [LW-1:0] r_rd_cnt;
  logic [W-1:0]  r_head;

  logic [LW-1:0] w_level;
  logic          w_pop;
  logic          w_push;
  logic [LW-1:0] w_rd_nxt;
  logic [AW-1:0] w_wr_idx;
  logic [AW-1:0] w_rd_nxt_idx;
  logic [W-1:0]  w_head_nxt;

  assign w_level      = r_wr_cnt - r_rd_cnt;
  assign o_empty      = (w_level == '0);
  assign o_full       = (w_level == LW'(D));
  assign w_pop        = i_pop && !o_empty;
  assign w_push       = i_push && (!o_full || w_pop);
  assign w_rd_nxt     = r_rd_cnt + LW'(w_pop);
  assign w_wr_idx     = r_wr_cnt[AW-1:0];
  assign w_rd_nxt_idx = w_rd_nxt[AW-1:0];

  // Next head: bypass the write data when it lands in the head slot.
  always_comb begin
    w_head_nxt = r_mem[w_rd_nxt_idx];
    if (w_push && (w_wr_idx == w_rd_nxt_idx)) begin
      w_head_nxt = i_data;
    end
  end

  // Storage array; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[w_wr_idx] <= i_data;
    end
  end

  // Free-running write/read counters wrap modulo 2*D.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_cnt <= '0;
      r_rd_cnt <= '0;
    end else begin
      if (w_push) r_wr_cnt <= r_wr_cnt + LW'(1);
      if (w_pop)  r_rd_cnt <= w_rd_nxt;
    end
  end

  // Registered head of queue.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_head <= '0;
    end else if (w_push || w_pop) begin
      r_head <= w_head_nxt;
    end
  end

  assign o_data  = r_head;
  assign o_level = w_level;

endmodule

// File: rtl/pio_cmd_fifo.sv
// pio_cmd_fifo: turns a strobe-less PIO level into queued commands.
// Build option PIO_CMD_ZERO_FILTER_EN: changes to zero are not queued.
module pio_cmd_fifo
  import pio_cmd_pkg::*;
#(
  parameter int DATA_W      = DEF_DATA_W,
  parameter int DEPTH       = DEF_DEPTH,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [DATA_W-1:0]         pio_in,
  output logic                      cmd_valid,
  output logic [DATA_W-1:0]         cmd_data,
  input  logic                      cmd_ready,
  output logic [level_w(DEPTH)-1:0] level,
  output logic                      overflow,
  input  logic                      clr_overflow
);

  logic [DATA_W-1:0] r_sync [SYNC_STAGES];
  logic [DATA_W-1:0] r_prev;
  logic              r_overflow;

  logic [DATA_W-1:0] w_sync_val;
  logic              w_change;
  logic              w_push;
  logic              w_pop;
  logic              w_full;
  logic              w_empty;
  logic              w_drop;

  // Level synchronizer on the PIO output.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < SYNC_STAGES; i++) r_sync[i] <= '0;
    end else begin
      r_sync[0] <= pio_in;
      for (int i = 1; i < SYNC_STAGES; i++) r_sync[i] <= r_sync[i-1];
    end
  end

  assign w_sync_val = r_sync[SYNC_STAGES-1];
  assign w_change   = (w_sync_val != r_prev);

  // Last seen value; tracks even dropped or filtered values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_prev <= '0;
    end else begin
      r_prev <= w_sync_val;
    end
  end

`ifdef PIO_CMD_ZERO_FILTER_EN
  assign w_push = w_change && (w_sync_val != '0);
`else
  assign w_push = w_change;
`endif

  assign w_pop  = cmd_valid && cmd_ready;
  assign w_drop = w_push && w_full && !w_pop;

  // Sticky drop flag; a new drop wins over a clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_overflow <= 1'b0;
    end else if (w_drop) begin
      r_overflow <= 1'b1;
    end else if (clr_overflow) begin
      r_overflow <= 1'b0;
    end
  end

  pio_cmd_sync_fifo #(
    .W (DATA_W),
    .D (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_push),
    .i_data  (w_sync_val),
    .i_pop   (w_pop),
    .o_data  (cmd_data),
    .o_level (level),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign cmd_valid = !w_empty;
  assign overflow  = r_overflow;

endmodule
